// File: rtl/seqswitch_sched.sv
// seqswitch_sched: programmable step scheduler for the sequential-switch routing mux.
// Optional divider: define SEQSWITCH_SCHED_CLKDIV_EN to make clk_div active.
// Ports: clk/rst (async, active-high); sample_strobe qualifies all CV evaluation;
//   sample_in0 clock CV, sample_in1 reset CV; length/mode/hold/clk_div controls;
//   route + step_pulse to the mux; sample_out0 gate CV; sample_out1 step CV.
module seqswitch_sched #(
  parameter int SCHMITT_HI   = 8000,
  parameter int SCHMITT_LO   = 2000,
  parameter int OUT_HI       = 20000,
  parameter int STEP_MV      = 4000,
  parameter int GATE_SAMPLES = 240
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_strobe,
  input  logic signed [15:0] sample_in0,
  input  logic signed [15:0] sample_in1,
  input  logic [1:0]         length,
  input  logic [1:0]         mode,
  input  logic               hold,
  input  logic [2:0]         clk_div,
  output logic [1:0]         route,
  output logic               step_pulse,
  output logic signed [15:0] sample_out0,
  output logic signed [15:0] sample_out1
);

  localparam int GW = $clog2(GATE_SAMPLES + 1);

  localparam logic signed [15:0] TH_HI = 16'(SCHMITT_HI);
  localparam logic signed [15:0] TH_LO = 16'(SCHMITT_LO);
  localparam logic [15:0]        OUT_W = 16'(OUT_HI);
  localparam logic [15:0]        STEP_W = 16'(STEP_MV);
  localparam logic [GW-1:0]      GATE_W = GW'(GATE_SAMPLES);
  localparam logic [GW-1:0]      ONE_W  = GW'(1);

  logic          s0_q, s0_d;
  logic          s1_q, s1_d;
  logic [1:0]    route_q, route_d;
  logic          pulse_q, pulse_d;
  logic          dn_q, dn_d;
  logic [GW-1:0] gate_q, gate_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [15:0]   out0_q, out0_d;
  logic [15:0]   out1_q, out1_d;

  logic          clk_rise;
  logic          rst_rise;
  logic          adv;
  logic [1:0]    nxt;
  logic          nxt_dn;
  logic [1:0]    rnd;

`ifdef SEQSWITCH_SCHED_CLKDIV_EN
  logic [2:0]    div_q, div_d;
`else
  logic          unused_clk_div;
  assign unused_clk_div = ^clk_div;
`endif

  assign rnd = lfsr_q[1:0];

  // Next-step rules; length is L-1, so "route+1 >= L" is "route >= length".
  always_comb begin
    nxt    = route_q;
    nxt_dn = dn_q;
    case (mode)
      2'd0: nxt = (route_q >= length) ? 2'd0 : route_q + 2'd1;
      2'd1: nxt = (route_q == 2'd0 || route_q > length) ?
                  length : route_q - 2'd1;
      2'd2: begin
        if (length == 2'd0) begin
          nxt = 2'd0;
        end else if (!dn_q) begin
          if (route_q >= length) begin
            nxt_dn = 1'b1;
            nxt    = length - 2'd1;
          end else begin
            nxt = route_q + 2'd1;
          end
        end else if (route_q == 2'd0) begin
          nxt_dn = 1'b0;
          nxt    = 2'd1;
        end else begin
          nxt = route_q - 2'd1;
        end
      end
      default: nxt = (rnd <= length) ? rnd : rnd - length - 2'd1;
    endcase
  end

  always_comb begin
    s0_d    = s0_q;
    s1_d    = s1_q;
    route_d = route_q;
    dn_d    = dn_q;
    gate_d  = gate_q;
    pulse_d = 1'b0;
    adv     = 1'b0;
    lfsr_d  = {lfsr_q[6:0],
               lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    out0_d  = (gate_q != '0) ? OUT_W : 16'd0;
    out1_d  = STEP_W * {14'd0, route_q};
`ifdef SEQSWITCH_SCHED_CLKDIV_EN
    div_d   = div_q;
`endif

    clk_rise = sample_strobe && !s0_q && (sample_in0 > TH_HI);
    rst_rise = sample_strobe && !s1_q && (sample_in1 > TH_HI);

    if (sample_strobe) begin
      s0_d = s0_q ? !(sample_in0 < TH_LO) : (sample_in0 > TH_HI);
      s1_d = s1_q ? !(sample_in1 < TH_LO) : (sample_in1 > TH_HI);
      if (gate_q != '0) gate_d = gate_q - ONE_W;
    end

    // Reset CV wins and swallows a coincident clock edge.
    if (rst_rise) begin
      route_d = 2'd0;
      dn_d    = 1'b0;
      pulse_d = 1'b1;
      gate_d  = GATE_W;
`ifdef SEQSWITCH_SCHED_CLKDIV_EN
      div_d   = 3'd0;
`endif
    end else if (clk_rise && !hold) begin
`ifdef SEQSWITCH_SCHED_CLKDIV_EN
      if (div_q == clk_div) begin
        adv   = 1'b1;
        div_d = 3'd0;
      end else begin
        div_d = div_q + 3'd1;
      end
`else
      adv = 1'b1;
`endif
    end

    if (adv) begin
      route_d = nxt;
      dn_d    = nxt_dn;
      pulse_d = 1'b1;
      gate_d  = GATE_W;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      route_q <= 2'd0;
      pulse_q <= 1'b0;
      dn_q    <= 1'b0;
      gate_q  <= '0;
      lfsr_q  <= 8'hA5;
      out0_q  <= 16'd0;
      out1_q  <= 16'd0;
`ifdef SEQSWITCH_SCHED_CLKDIV_EN
      div_q   <= 3'd0;
`endif
    end else begin
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      route_q <= route_d;
      pulse_q <= pulse_d;
      dn_q    <= dn_d;
      gate_q  <= gate_d;
      lfsr_q  <= lfsr_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
`ifdef SEQSWITCH_SCHED_CLKDIV_EN
      div_q   <= div_d;
`endif
    end
  end

  assign route       = route_q;
  assign step_pulse  = pulse_q;
  assign sample_out0 = $signed(out0_q);
  assign sample_out1 = $signed(out1_q);

endmodule

// File: tb/tb_seqswitch_sched.sv
// tb_seqswitch_sched: randomized + directed bench for seqswitch_sched,
// checked against a step-rule reference model kept in the bench.
module tb_seqswitch_sched;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sample_strobe = 1'b0;
  logic signed [15:0] sample_in0 = '0;
  logic signed [15:0] sample_in1 = '0;
  logic [1:0]         length = '0;
  logic [1:0]         mode = '0;
  logic               hold = 1'b0;
  logic [2:0]         clk_div = '0;
  logic [1:0]         route;
  logic               step_pulse;
  logic signed [15:0] sample_out0;
  logic signed [15:0] sample_out1;

  seqswitch_sched dut (
    .clk(clk), .rst(rst), .sample_strobe(sample_strobe),
    .sample_in0(sample_in0), .sample_in1(sample_in1),
    .length(length), .mode(mode), .hold(hold), .clk_div(clk_div),
    .route(route), .step_pulse(step_pulse),
    .sample_out0(sample_out0), .sample_out1(sample_out1)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  bit m_s0, m_s1, m_up;
  int m_route, m_gate, m_div;
  bit e_pulse;
  int e_o0, e_o1;

  // observed values from the last strobe
  logic [1:0]         obs_route;
  logic               obs_pulse, obs_pulse2;
  logic signed [15:0] obs_o0, obs_o1;

  task automatic model_reset();
    m_s0 = 0; m_s1 = 0; m_up = 1;
    m_route = 0; m_gate = 0; m_div = 0;
  endtask

  task automatic model_advance();
    int L;
    L = int'(length) + 1;
    case (mode)
      2'd0: m_route = (m_route + 1 >= L) ? 0 : m_route + 1;
      2'd1: m_route = (m_route == 0 || m_route >= L) ? L - 1 : m_route - 1;
      2'd2: begin
        if (L == 1) m_route = 0;
        else if (m_up) begin
          if (m_route >= L - 1) begin m_up = 0; m_route = L - 2; end
          else m_route = m_route + 1;
        end else begin
          if (m_route == 0) begin m_up = 1; m_route = 1; end
          else m_route = m_route - 1;
        end
      end
      default: m_route = -1;
    endcase
  endtask

  task automatic model_step(input int a, input int b);
    bit r0, r1;
    r0 = !m_s0 && a > 8000;
    r1 = !m_s1 && b > 8000;
    if (m_s0) m_s0 = !(a < 2000); else m_s0 = a > 8000;
    if (m_s1) m_s1 = !(b < 2000); else m_s1 = b > 8000;
    if (m_gate > 0) m_gate = m_gate - 1;
    e_pulse = 0;
    if (r1) begin
      m_route = 0; m_up = 1; m_div = 0; e_pulse = 1; m_gate = 240;
    end else if (r0 && !hold) begin
`ifdef SEQSWITCH_SCHED_CLKDIV_EN
      if (m_div == int'(clk_div)) begin
        m_div = 0; e_pulse = 1;
      end else begin
        m_div = (m_div + 1) % 8;
      end
`else
      e_pulse = 1;
`endif
      if (e_pulse) begin
        model_advance();
        m_gate = 240;
      end
    end
    e_o0 = (m_gate != 0) ? 20000 : 0;
    e_o1 = m_route * 4000;
  endtask

  task automatic strobe(input logic signed [15:0] a,
                        input logic signed [15:0] b);
    @(negedge clk);
    sample_in0 = a; sample_in1 = b; sample_strobe = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
    obs_pulse = step_pulse; obs_route = route;
    @(negedge clk);
    obs_pulse2 = step_pulse; obs_o0 = sample_out0; obs_o1 = sample_out1;
    model_step(int'(a), int'(b));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sample_strobe = 1'b0;
    sample_in0 = '0; sample_in1 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_vec++;
    if (route !== 2'd0 || step_pulse !== 1'b0 ||
        sample_out0 !== 16'sd0 || sample_out1 !== 16'sd0) begin
      n_bad++;
      $display("FAIL reset_state got r=%0d p=%0b o0=%0d o1=%0d want 0 0 0 0",
               route, step_pulse, sample_out0, sample_out1);
    end
  endtask

  task automatic test_forward();
    logic [1:0] exp_r [5] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    int exp_o1 [5] = '{4000, 8000, 0, 4000, 8000};
    do_reset();
    mode = 2'd0; length = 2'd2; hold = 0; clk_div = 3'd0;
    for (int i = 0; i < 5; i++) begin
      strobe(16'sd20000, 16'sd0);
      n_vec++;
      if (obs_route !== exp_r[i] || obs_pulse !== 1'b1 ||
          obs_pulse2 !== 1'b0 || obs_o1 !== 16'(exp_o1[i])) begin
        n_bad++;
        $display("FAIL fwd[%0d] got r=%0d p=%0b%0b o1=%0d want r=%0d p=10 o1=%0d",
                 i, obs_route, obs_pulse, obs_pulse2, obs_o1, exp_r[i], exp_o1[i]);
      end
      strobe(16'sd0, 16'sd0);
    end
  endtask

  task automatic test_schmitt();
    int np;
    np = 0;
    mode = 2'd0; length = 2'd3; hold = 0; clk_div = 3'd0;
    for (int v = 0; v <= 6000; v += 500) begin
      strobe(16'(v), 16'sd0); np += int'(obs_pulse);
    end
    for (int v = 5500; v >= 4000; v -= 500) begin
      strobe(16'(v), 16'sd0); np += int'(obs_pulse);
    end
    for (int v = 4500; v <= 10000; v += 500) begin
      strobe(16'(v), 16'sd0); np += int'(obs_pulse);
    end
    for (int v = 9000; v >= 0; v -= 1000) begin
      strobe(16'(v), 16'sd0); np += int'(obs_pulse);
    end
    n_vec++;
    if (np !== 1) begin
      n_bad++;
      $display("FAIL schmitt_ramp got %0d advances want 1", np);
    end
    np = 0;
    for (int i = 0; i < 100; i++) begin
      strobe(16'($urandom_range(2000, 8000)), 16'sd0);
      np += int'(obs_pulse);
    end
    n_vec++;
    if (np !== 0) begin
      n_bad++;
      $display("FAIL schmitt_band got %0d advances want 0", np);
    end
  endtask

  task automatic test_pingpong();
    logic [1:0] exp_r [7] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
    do_reset();
    mode = 2'd2; length = 2'd3; hold = 0; clk_div = 3'd0;
    for (int i = 0; i < 7; i++) begin
      strobe(16'sd20000, 16'sd0);
      n_vec++;
      if (obs_route !== exp_r[i] || obs_pulse !== 1'b1) begin
        n_bad++;
        $display("FAIL pingpong[%0d] got r=%0d p=%0b want r=%0d p=1",
                 i, obs_route, obs_pulse, exp_r[i]);
      end
      strobe(16'sd0, 16'sd0);
    end
  endtask

  task automatic test_reverse();
    strobe(16'sd0, 16'sd20000);
    strobe(16'sd0, 16'sd0);
    mode = 2'd1; length = 2'd2;
    strobe(16'sd20000, 16'sd0);
    n_vec++;
    if (obs_route !== 2'd2 || obs_o1 !== 16'sd8000) begin
      n_bad++;
      $display("FAIL reverse_wrap got r=%0d o1=%0d want r=2 o1=8000",
               obs_route, obs_o1);
    end
    strobe(16'sd0, 16'sd0);
    strobe(16'sd20000, 16'sd0);
    n_vec++;
    if (obs_route !== 2'd1) begin
      n_bad++;
      $display("FAIL reverse_step got %0d want 1", obs_route);
    end
    strobe(16'sd0, 16'sd0);
  endtask

  task automatic test_reset_async();
    do_reset();
    mode = 2'd0; length = 2'd2; hold = 0; clk_div = 3'd0;
    repeat (2) begin
      strobe(16'sd20000, 16'sd0);
      strobe(16'sd0, 16'sd0);
    end
    n_vec++;
    if (route !== 2'd2 || sample_out0 !== 16'sd20000) begin
      n_bad++;
      $display("FAIL async_setup got r=%0d o0=%0d want r=2 o0=20000",
               route, sample_out0);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (route !== 2'd0 || sample_out0 !== 16'sd0 ||
        sample_out1 !== 16'sd0 || step_pulse !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset got r=%0d o0=%0d o1=%0d p=%0b want 0 0 0 0",
               route, sample_out0, sample_out1, step_pulse);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_gate_hold();
    int nhigh, last_high;
    do_reset();
    mode = 2'd0; length = 2'd3; hold = 0; clk_div = 3'd0;
    repeat (2) begin
      strobe(16'sd20000, 16'sd0);
      strobe(16'sd0, 16'sd0);
    end
    hold = 1;
    strobe(16'sd20000, 16'sd0);
    n_vec++;
    if (obs_pulse !== 1'b0 || obs_route !== 2'd2) begin
      n_bad++;
      $display("FAIL hold_clock got p=%0b r=%0d want p=0 r=2",
               obs_pulse, obs_route);
    end
    strobe(16'sd0, 16'sd0);
    repeat (250) strobe(16'sd0, 16'sd0);
    strobe(16'sd20000, 16'sd20000);
    n_vec++;
    if (obs_route !== 2'd0 || obs_pulse !== 1'b1 || obs_pulse2 !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_rstcv got r=%0d p=%0b%0b want r=0 p=10",
               obs_route, obs_pulse, obs_pulse2);
    end
    nhigh = int'(obs_o0 == 16'sd20000);
    last_high = nhigh ? 0 : -1;
    for (int k = 1; k <= 400; k++) begin
      if (k == 100) strobe(16'sd0, 16'sd20000);
      else          strobe(16'sd0, 16'sd0);
      if (obs_o0 == 16'sd20000) begin
        nhigh++; last_high = k;
      end
    end
    n_vec++;
    if (nhigh !== 340 || last_high !== 339) begin
      n_bad++;
      $display("FAIL gate_len got high=%0d last=%0d want high=340 last=339",
               nhigh, last_high);
    end
    hold = 0;
  endtask

  task automatic test_clkdiv();
`ifdef SEQSWITCH_SCHED_CLKDIV_EN
    logic [1:0] exp_r [9] = '{0, 0, 1, 1, 1, 2, 2, 2, 3};
    logic       exp_p [9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
`else
    logic [1:0] exp_r [9] = '{1, 2, 3, 0, 1, 2, 3, 0, 1};
    logic       exp_p [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif
    do_reset();
    mode = 2'd0; length = 2'd3; hold = 0; clk_div = 3'd2;
    for (int i = 0; i < 9; i++) begin
      strobe(16'sd20000, 16'sd0);
      n_vec++;
      if (obs_route !== exp_r[i] || obs_pulse !== exp_p[i]) begin
        n_bad++;
        $display("FAIL clkdiv[%0d] got r=%0d p=%0b want r=%0d p=%0b",
                 i, obs_route, obs_pulse, exp_r[i], exp_p[i]);
      end
      strobe(16'sd0, 16'sd0);
    end
    clk_div = 3'd0;
  endtask

  task automatic test_random_mode();
    do_reset();
    mode = 2'd3; hold = 0; clk_div = 3'd0;
    for (int i = 0; i < 40; i++) begin
      length = 2'($urandom_range(1, 3));
      strobe(16'sd20000, 16'sd0);
      n_vec++;
      if (obs_pulse !== 1'b1 || obs_route > length) begin
        n_bad++;
        $display("FAIL random[%0d] got r=%0d p=%0b want r<=%0d p=1",
                 i, obs_route, obs_pulse, length);
      end
      strobe(16'sd0, 16'sd0);
    end
    strobe(16'sd0, 16'sd20000);
    strobe(16'sd0, 16'sd0);
    mode = 2'd0;
  endtask

  function automatic logic signed [15:0] pick(input int hi_pct);
    int r;
    r = int'($urandom_range(0, 99));
    if (r < hi_pct) return 16'($urandom_range(8001, 30000));
    if (r < hi_pct + 25) return 16'($urandom_range(2000, 8000));
    return 16'(int'($urandom_range(0, 3999)) - 2000);
  endfunction

  task automatic test_random_stream();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      mode    = 2'($urandom_range(0, 2));
      length  = 2'($urandom_range(0, 3));
      hold    = ($urandom_range(0, 3) == 0);
      clk_div = 3'($urandom_range(0, 3));
      strobe(pick(50), pick(8));
      n_vec++;
      if (obs_pulse !== e_pulse || obs_pulse2 !== 1'b0 ||
          obs_route !== 2'(m_route) ||
          obs_o0 !== 16'(e_o0) || obs_o1 !== 16'(e_o1)) begin
        n_bad++;
        $display("FAIL stream[%0d] got p=%0b%0b r=%0d o0=%0d o1=%0d want p=%0b0 r=%0d o0=%0d o1=%0d",
                 i, obs_pulse, obs_pulse2, obs_route, obs_o0, obs_o1,
                 e_pulse, m_route, e_o0, e_o1);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_forward();
    test_schmitt();
    test_pingpong();
    test_reverse();
    test_reset_async();
    test_gate_hold();
    test_clkdiv();
    test_random_mode();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
